// File: rtl/controle_multiciclo_if.sv
// Bus bundle between the multicycle controller and its datapath/memories.
// master = controller side, slave = datapath/memory side.
interface controle_multiciclo_if #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned DATA_W = 8
);
    logic [PC_W-1:0]   I_addr;
    logic              I_rd;
    logic              I_ack;
    logic [15:0]       I_data;
    logic [7:0]        D_addr;
    logic              D_rd;
    logic              D_wr;
    logic              D_ack;
    logic [DATA_W-1:0] RF_W_data;
    logic              RF_s1;
    logic              RF_s0;
    logic [3:0]        RF_W_addr;
    logic [3:0]        RF_Rp_addr;
    logic [3:0]        RF_Rq_addr;
    logic              RF_W_wr;
    logic              RF_Rp_rd;
    logic              RF_Rq_rd;
    logic              RF_Rp_zero;
    logic              alu_s1;
    logic              alu_s0;
    logic              halted;
    logic              err;

    modport master (
        output I_addr, I_rd, D_addr, D_rd, D_wr,
               RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
               RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0, halted, err,
        input  I_ack, I_data, D_ack, RF_Rp_zero
    );

    modport slave (
        input  I_addr, I_rd, D_addr, D_rd, D_wr,
               RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
               RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0, halted, err,
        output I_ack, I_data, D_ack, RF_Rp_zero
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: PC/IR, fetch/decode/execute FSM with memory
// handshakes, signed relative jumps, HALT and sticky illegal-opcode state.
module controle_multiciclo #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MEM_HS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    controle_multiciclo_if.master bus
);
    typedef enum logic [3:0] {
        INICIO         = 4'd0,
        BUSCA          = 4'd1,
        DECOD          = 4'd2,
        CARREGAR       = 4'd3,
        ARMAZENAR      = 4'd4,
        SOMAR          = 4'd5,
        SUBTRAIR       = 4'd6,
        CARREGAR_CONST = 4'd7,
        TESTAR         = 4'd8,
        SALTAR         = 4'd9,
        PARADO         = 4'd10,
        ERRO           = 4'd11
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;

    logic [3:0]        op, ra, rb, rc;
    logic [7:0]        imm;
    logic [PC_W-1:0]   off_ext;
    logic              i_ack_eff, d_ack_eff;

    logic              i_rd, d_rd, d_wr;
    logic [7:0]        d_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic [1:0]        rf_s, alu_s;
    logic [3:0]        rf_w_addr, rf_rp_addr, rf_rq_addr;
    logic              rf_w_wr, rf_rp_rd, rf_rq_rd;
    logic              halted, err;

    assign op      = ir_q[15:12];
    assign ra      = ir_q[11:8];
    assign rb      = ir_q[7:4];
    assign rc      = ir_q[3:0];
    assign imm     = ir_q[7:0];
    assign off_ext = PC_W'($signed(imm));

    assign i_ack_eff = (MEM_HS != 0) ? bus.I_ack : 1'b1;
    assign d_ack_eff = (MEM_HS != 0) ? bus.D_ack : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INICIO;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        i_rd       = 1'b0;
        d_rd       = 1'b0;
        d_wr       = 1'b0;
        d_addr     = '0;
        rf_w_data  = '0;
        rf_s       = '0;
        rf_w_addr  = '0;
        rf_rp_addr = '0;
        rf_rq_addr = '0;
        rf_w_wr    = 1'b0;
        rf_rp_rd   = 1'b0;
        rf_rq_rd   = 1'b0;
        alu_s      = '0;
        halted     = 1'b0;
        err        = 1'b0;

        case (state_q)
            INICIO: begin
                pc_d    = '0;
                state_d = BUSCA;
            end
            BUSCA: begin
                i_rd = 1'b1;
                if (i_ack_eff) begin
                    ir_d    = bus.I_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = DECOD;
                end
            end
            DECOD: begin
                case (op)
                    4'd0:       state_d = CARREGAR;
                    4'd1:       state_d = ARMAZENAR;
                    4'd2:       state_d = SOMAR;
                    4'd3:       state_d = CARREGAR_CONST;
                    4'd4:       state_d = SUBTRAIR;
                    4'd5, 4'd7: state_d = TESTAR;
                    4'd6:       state_d = SALTAR;
                    4'd8:       state_d = PARADO;
                    default:    state_d = ERRO;
                endcase
            end
            CARREGAR: begin
                // Write strobe follows the ack so a stalled load writes once.
                d_addr    = imm;
                d_rd      = 1'b1;
                rf_s      = 2'b01;
                rf_w_addr = ra;
                rf_w_wr   = d_ack_eff;
                if (d_ack_eff) state_d = BUSCA;
            end
            ARMAZENAR: begin
                d_addr     = imm;
                d_wr       = 1'b1;
                rf_rp_addr = ra;
                rf_rp_rd   = 1'b1;
                if (d_ack_eff) state_d = BUSCA;
            end
            SOMAR, SUBTRAIR: begin
                rf_rp_addr = rb;
                rf_rq_addr = rc;
                rf_rp_rd   = 1'b1;
                rf_rq_rd   = 1'b1;
                rf_w_addr  = ra;
                rf_w_wr    = 1'b1;
                alu_s      = (state_q == SOMAR) ? 2'b01 : 2'b10;
                state_d    = BUSCA;
            end
            CARREGAR_CONST: begin
                rf_s      = 2'b10;
                rf_w_data = DATA_W'(imm);
                rf_w_addr = ra;
                rf_w_wr   = 1'b1;
                state_d   = BUSCA;
            end
            TESTAR: begin
                rf_rp_addr = ra;
                rf_rp_rd   = 1'b1;
                if ((op == 4'd7) ? !bus.RF_Rp_zero : bus.RF_Rp_zero)
                    state_d = SALTAR;
                else
                    state_d = BUSCA;
            end
            SALTAR: begin
                // PC already points past the jump; -1 makes off relative to it.
                pc_d    = pc_q + off_ext - PC_W'(1);
                state_d = BUSCA;
            end
            PARADO:  halted = 1'b1;
            ERRO:    err    = 1'b1;
            default: state_d = INICIO;
        endcase
    end

    assign bus.I_addr     = pc_q;
    assign bus.I_rd       = i_rd;
    assign bus.D_addr     = d_addr;
    assign bus.D_rd       = d_rd;
    assign bus.D_wr       = d_wr;
    assign bus.RF_W_data  = rf_w_data;
    assign bus.RF_s1      = rf_s[1];
    assign bus.RF_s0      = rf_s[0];
    assign bus.RF_W_addr  = rf_w_addr;
    assign bus.RF_Rp_addr = rf_rp_addr;
    assign bus.RF_Rq_addr = rf_rq_addr;
    assign bus.RF_W_wr    = rf_w_wr;
    assign bus.RF_Rp_rd   = rf_rp_rd;
    assign bus.RF_Rq_rd   = rf_rq_rd;
    assign bus.alu_s1     = alu_s[1];
    assign bus.alu_s0     = alu_s[0];
    assign bus.halted     = halted;
    assign bus.err        = err;
endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Parametrised multicycle control unit for the 6-instruction processor datapath. It holds the program counter (PC) and instruction register (IR), fetches 16-bit instructions from instruction memory, and decodes and sequences each instruction through an FSM. Every cycle it drives the register-file, ALU and data-memory control lines. Compared with the fixed controller it adds three things:
- Ready/ack handshakes on instruction and data memory, so wait states are supported.
- Signed relative jumps, including unconditional JMP and JMPNZ.
- A HALT instruction and a sticky illegal-opcode error.

## Interface
Parameters:
- PC_W, 16, width of PC and I_addr; 8..16.
- DATA_W, 8, width of RF_W_data; ≥8. The 8-bit constant is zero-extended to DATA_W.
- MEM_HS, 1, enables the memory handshakes. When 1, I_ack and D_ack are honoured. When 0, both acks are treated as constant 1.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- I_addr  out  PC_W  instruction address; equals PC.
- I_rd  out  1  instruction read request.
- I_ack  in  1  instruction word valid on I_data this cycle.
- I_data  in  16  instruction word.
- D_addr  out  8  data-memory address, taken from IR[7:0].
- D_rd, D_wr  out  1  data read and write requests.
- D_ack  in  1  data access completes this cycle.
- RF_W_data  out  DATA_W  constant for MOVC.
- RF_s1, RF_s0  out  1  RF write-mux select: 00 = ALU, 01 = memory, 10 = constant.
- RF_W_addr, RF_Rp_addr, RF_Rq_addr  out  4  register addresses.
- RF_W_wr, RF_Rp_rd, RF_Rq_rd  out  1  register-file enables.
- RF_Rp_zero  in  1  read port Rp value == 0.
- alu_s1, alu_s0  out  1  ALU op: 00 = pass, 01 = add, 10 = sub.
- halted  out  1  high while in state PARADO.
- err  out  1  high while in state ERRO (illegal opcode).

## Operation
Instruction fields:
- op = IR[15:12], Ra = IR[11:8], Rb = IR[7:4], Rc = IR[3:0].
- d/C/off = IR[7:0]. off is signed (two's complement).

Opcodes:
- 0 MOVR: Ra ← M[d].
- 1 MOVD: M[d] ← Ra.
- 2 ADD: Ra ← Rb + Rc.
- 3 MOVC: Ra ← C.
- 4 SUB: Ra ← Rb − Rc.
- 5 JMPZ: jump if Ra == 0.
- 6 JMP: unconditional jump.
- 7 JMPNZ: jump if Ra != 0.
- 8 HALT.
- 9–15: illegal.

FSM states:
- INICIO: PC_clr (PC ← 0). Next state BUSCA.
- BUSCA: I_rd = 1. Next state DECOD once I_ack is seen.
- DECOD: no outputs. Next state is selected by op:
  - 0 → CARREGAR
  - 1 → ARMAZENAR
  - 2 → SOMAR
  - 3 → CARREGAR_CONST
  - 4 → SUBTRAIR
  - 5 or 7 → TESTAR
  - 6 → SALTAR
  - 8 → PARADO
  - else → ERRO
- CARREGAR: D_addr = d, D_rd = 1, RF_s = 01, RF_W_addr = Ra. Next state BUSCA once D_ack is seen.
- ARMAZENAR: D_addr = d, D_wr = 1, RF_Rp_addr = Ra, RF_Rp_rd = 1. Next state BUSCA once D_ack is seen.
- SOMAR / SUBTRAIR: Rp = Rb, Rq = Rc (both read enables high), RF_s = 00, RF_W_addr = Ra, RF_W_wr = 1, alu = 01 / 10. Next state BUSCA.
- CARREGAR_CONST: RF_s = 10, RF_W_data = C zero-extended, RF_W_addr = Ra, RF_W_wr = 1. Next state BUSCA.
- TESTAR: RF_Rp_addr = Ra, RF_Rp_rd = 1. RF_Rp_zero is sampled this cycle:
  - JMPZ: SALTAR if RF_Rp_zero = 1, else BUSCA.
  - JMPNZ: SALTAR if RF_Rp_zero = 0, else BUSCA.
- SALTAR: PC ← PC + sext(off) − 1, modulo 2^PC_W, so the target is the jump's own address + off. Next state BUSCA.
- PARADO and ERRO: terminal. All control outputs are 0. Only reset exits.

Rules:
- Every output not listed for a state is 0.
- Any unreachable state encoding forces next state INICIO.

## Timing
- Reset (asynchronous, immediate): state = INICIO, PC = 0, IR = 0. All outputs are 0 except I_addr = 0.
- Reset mid-access: the request drops immediately and no register-file write occurs.
- Fetch handshake:
  - I_rd stays high until the cycle in which I_ack = 1.
  - On that edge: IR ← I_data, PC ← PC + 1 (wraps to 0 from 2^PC_W − 1).
  - An I_ack while I_rd = 0 is ignored.
- Load handshake (MOVR):
  - D_rd stays high until D_ack.
  - RF_W_wr is asserted only in the cycle D_ack = 1, so the register is written exactly once.
- Store handshake (MOVD): D_wr stays high until D_ack. D_addr and RF_Rp_addr are stable throughout.
- Cycle counts with zero wait states (MEM_HS = 0, or ack already high):
  - ALU, MOVC, MOVR, MOVD: 3 cycles.
  - JMPZ/JMPNZ not taken: 3 cycles; taken: 4 cycles.
  - JMP: 3 cycles.
  - Each wait cycle adds one cycle.
- Jump offsets:
  - off = 0 jumps to self (legal).
  - off = 0x80 gives a target of −128.
- halted and err rise in the cycle after DECOD.

## Test plan
- Reset, then MOVC R1,0x05; ADD R2,R1,R1; SUB R3,R2,R1, with zero wait → RF writes R1 = 05, R2 = 0A, R3 = 05. Each instruction takes 3 cycles; PC = 3 afterwards.
- MOVR R4,0x10 with D_ack delayed 3 cycles → D_rd held 4 cycles, D_addr = 0x10 throughout, exactly one RF_W_wr pulse to R4 in the ack cycle. Same check with I_ack delayed: I_rd held, PC increments once.
- JMPZ R0,0xFE at address 5:
  - RF_Rp_zero = 1 → next I_addr = 3.
  - RF_Rp_zero = 0 → next I_addr = 6.
  - JMPNZ with the same stimulus → the opposite outcomes.
- PC_W = 8: JMP +2 at 0xFF → I_addr = 0x01 (wrap). JMP 0x00 → refetches the same address.
- HALT → halted = 1 and all requests stay 0 for 20 cycles. Opcode 0xC → err = 1. Reset → INICIO, then I_addr = 0.
- Reset asserted mid-MOVR (D_rd high, no ack) → D_rd = 0 immediately, no RF write, fetch restarts at address 0.
